// File: rtl/encrypt_pkg.sv
// Shared types and helpers for the pipelined encryption unit.
//   ctrl_state_t : control FSM states (UNKEYED, READY, RUN)
//   rotl()       : rotate-left of the low `width` bits of a ROTL_MAX_W-bit value
//   DEFAULT_*    : default parameter values for the unit
package encrypt_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ROUNDS = 4;

    // Widest datapath rotl() can handle; callers zero-extend into and truncate out of it.
    localparam int unsigned ROTL_MAX_W = 64;
    localparam int unsigned ROTL_IDX_W = $clog2(ROTL_MAX_W);

    typedef enum logic [1:0] {
        UNKEYED,
        READY,
        RUN
    } ctrl_state_t;

    // Rotates value[width-1:0] left by `amount`; bits at and above `width` come back as 0.
    function automatic logic [ROTL_MAX_W-1:0] rotl(input logic [ROTL_MAX_W-1:0] value,
                                                    input int unsigned           amount,
                                                    input int unsigned           width);
        logic [ROTL_MAX_W-1:0] res;
        res = '0;
        for (int unsigned b = 0; b < ROTL_MAX_W; b++) begin
            if (b < width) begin
                res[ROTL_IDX_W'((b + amount) % width)] = value[ROTL_IDX_W'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/encrypt_round.sv
// One registered encryption round: data_o <= f(data_i ^ rk_i), valid_o <= valid_i.
// Optional macro SHIFT_STAGE_EN: f = rotate-left by 1; otherwise f = identity.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   valid_i, data_i   word entering this round
//   rk_i              round key for this stage
//   valid_o, data_o   registered round result
module encrypt_round
    import encrypt_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] rk_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] xored, mixed;

    always_comb begin
        xored = data_i ^ rk_i;
`ifdef SHIFT_STAGE_EN
        mixed = DATA_W'(rotl(ROTL_MAX_W'(xored), 1, DATA_W));
`else
        mixed = xored;
`endif
        valid_d = valid_i;
        // Data only moves with a valid word, so idle stages do not toggle.
        data_d  = valid_i ? mixed : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/encrypt_unit_pipe.sv
// Pipelined XOR/rotate encryption unit with run-time key load.
// A word accepted on edge N leaves with v=1 after edge N+ROUNDS.
// Optional macro SHIFT_STAGE_EN: each round rotates its result left by one bit.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cfg_en, cfg_key   key-load strobe and key value (rejected while words are in flight)
//   en, din           input-valid strobe and plaintext
//   key_ok            a key has been loaded since reset
//   cfg_err           one-cycle pulse for a rejected key load
//   v, dout           ciphertext valid and word (dout holds while v=0)
module encrypt_unit_pipe
    import encrypt_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ROUNDS = DEFAULT_ROUNDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic              key_ok,
    output logic              cfg_err,
    output logic              v,
    output logic [DATA_W-1:0] dout
);

    // Stages 0..ROUNDS-2; a valid bit here means a stage will still be valid after this edge.
    localparam logic [ROUNDS-1:0] INNER_MASK = {ROUNDS{1'b1}} >> 1;

    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              key_ok_q, key_ok_d;
    logic              cfg_err_q, cfg_err_d;
    logic              v_q, v_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              key_load, key_reject, accept, any_valid_d;
    logic [ROUNDS-1:0] stage_valid;
    logic [DATA_W-1:0] stage_data [ROUNDS];

    always_comb begin
        key_load    = cfg_en && (state_q != RUN);
        key_reject  = cfg_en && (state_q == RUN);
        // cfg_en always wins over en, even when the load itself is rejected.
        accept      = en && !cfg_en && key_ok_q;
        any_valid_d = accept || (|(stage_valid & INNER_MASK));

        state_d = state_q;
        unique case (state_q)
            UNKEYED: if (key_load)     state_d = READY;
            READY:   if (accept)       state_d = RUN;
            RUN:     if (!any_valid_d) state_d = READY;
            default:                   state_d = UNKEYED;
        endcase

        key_d     = key_load ? cfg_key : key_q;
        key_ok_d  = key_ok_q || key_load;
        cfg_err_d = key_reject;
        v_d       = stage_valid[ROUNDS-1];
        dout_d    = v_d ? stage_data[ROUNDS-1] : dout_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UNKEYED;
            key_q     <= '0;
            key_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            v_q       <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            key_ok_q  <= key_ok_d;
            cfg_err_q <= cfg_err_d;
            v_q       <= v_d;
            dout_q    <= dout_d;
        end
    end

    for (genvar i = 0; i < ROUNDS; i++) begin : g_round
        logic              valid_in;
        logic [DATA_W-1:0] data_in;
        logic [DATA_W-1:0] rk;

        if (i == 0) begin : g_first
            assign valid_in = accept;
            assign data_in  = din;
        end else begin : g_next
            assign valid_in = stage_valid[i-1];
            assign data_in  = stage_data[i-1];
        end

        // Round key i is the loaded key rotated left by i.
        assign rk = DATA_W'(rotl(ROTL_MAX_W'(key_q), i, DATA_W));

        encrypt_round #(
            .DATA_W (DATA_W)
        ) u_round (
            .clk_i   (clk),
            .rst_ni  (rst),
            .valid_i (valid_in),
            .data_i  (data_in),
            .rk_i    (rk),
            .valid_o (stage_valid[i]),
            .data_o  (stage_data[i])
        );
    end

    assign key_ok  = key_ok_q;
    assign cfg_err = cfg_err_q;
    assign v       = v_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_encrypt_unit_pipe.sv
// Self-checking bench for encrypt_unit_pipe (DATA_W=8, ROUNDS=4).
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_encrypt_unit_pipe;

    localparam int  DW         = 8;
    localparam int  RN         = 4;
    localparam time CLK_PERIOD = 10;

`ifdef SHIFT_STAGE_EN
    localparam logic [DW-1:0] STREAM_EXP [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    localparam logic [DW-1:0] ZERO_KEY_EXP   = 8'hAF;
`else
    localparam logic [DW-1:0] STREAM_EXP [4] = '{8'h55, 8'h54, 8'h57, 8'h56};
    localparam logic [DW-1:0] ZERO_KEY_EXP   = 8'hFA;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_key = '0;
    logic          en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          key_ok, cfg_err, v;
    logic [DW-1:0] dout;

    always #(CLK_PERIOD / 2) clk = ~clk;

    encrypt_unit_pipe #(
        .DATA_W (DW),
        .ROUNDS (RN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_en  (cfg_en),
        .cfg_key (cfg_key),
        .en      (en),
        .din     (din),
        .key_ok  (key_ok),
        .cfg_err (cfg_err),
        .v       (v),
        .dout    (dout)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] rotl_m(input logic [DW-1:0] x, input int a);
        logic [2*DW-1:0] t;
        t = {x, x} << (a % DW);
        return t[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] enc_m(input logic [DW-1:0] x, input logic [DW-1:0] k);
        logic [DW-1:0] y;
        y = x;
        for (int i = 0; i < RN; i++) begin
            y = y ^ rotl_m(k, i);
`ifdef SHIFT_STAGE_EN
            y = rotl_m(y, 1);
`endif
        end
        return y;
    endfunction

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend_q[$];
    int            edge_n   = 0;
    int            last_acc = -1000;
    logic [DW-1:0] m_key    = '0;
    logic          m_keyok  = 1'b0;
    logic          m_err    = 1'b0;
    logic          m_v      = 1'b0;
    logic [DW-1:0] m_dout   = '0;
    logic          m_busy, m_acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q.delete();
            edge_n   = 0;
            last_acc = -1000;
            m_key    = '0;
            m_keyok  = 1'b0;
            m_err    = 1'b0;
            m_v      = 1'b0;
            m_dout   = '0;
        end else begin
            edge_n++;
            // Words still inside the rounds if one was accepted within the last RN edges.
            m_busy = (edge_n - last_acc) <= RN;
            m_acc  = en && !cfg_en && m_keyok;
            m_err  = cfg_en && m_busy;
            if (m_acc) begin
                pend_q.push_back('{due: edge_n + RN, data: enc_m(din, m_key)});
                last_acc = edge_n;
            end
            if (cfg_en && !m_busy) begin
                m_key   = cfg_key;
                m_keyok = 1'b1;
            end
            m_v = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                m_v    = 1'b1;
                m_dout = pend_q[0].data;
                void'(pend_q.pop_front());
            end
        end
    end

    logic cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_v", 32'(v), 32'(m_v));
            check("model_dout", 32'(dout), 32'(m_dout));
            check("model_key_ok", 32'(key_ok), 32'(m_keyok));
            check("model_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_key(input logic [DW-1:0] k);
        cfg_key = k;
        cfg_en  = 1'b1;
        @(negedge clk);
        cfg_en  = 1'b0;
    endtask

    task automatic wait_v(output int lat, input int start);
        lat = start;
        while (v !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_one(input string name, input logic [DW-1:0] d, input logic [DW-1:0] exp);
        int lat;
        en  = 1'b1;
        din = d;
        @(negedge clk);
        en  = 1'b0;
        wait_v(lat, 1);
        check({name, "_latency"}, 32'(lat), 32'(RN + 1));
        check({name, "_dout"}, 32'(dout), 32'(exp));
        cyc(2);
    endtask

    task automatic count_v(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (v === 1'b1) cnt++;
        end
    endtask

    initial begin
        int lat, cnt;
        #1 rst = 1'b0;
        cmp_on = 1'b1;
        cyc(3);
        check("reset_v", 32'(v), 32'd0);
        check("reset_key_ok", 32'(key_ok), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        rst = 1'b1;

        // Unkeyed: en ignored.
        en  = 1'b1;
        din = 8'hFA;
        cyc(3);
        en  = 1'b0;
        count_v(6, cnt);
        check("unkeyed_no_v", 32'(cnt), 32'd0);
        check("unkeyed_key_ok", 32'(key_ok), 32'd0);

        // Key load and single word.
        load_key(8'h3C);
        check("key_ok_after_load", 32'(key_ok), 32'd1);
        send_one("single_3c", 8'hFA, 8'hAF);

        load_key(8'h00);
        send_one("zero_key", 8'hFA, ZERO_KEY_EXP);

        // Back-to-back stream.
        load_key(8'h3C);
        for (int i = 0; i < 4; i++) begin
            en  = 1'b1;
            din = DW'(i);
            @(negedge clk);
        end
        en = 1'b0;
        wait_v(lat, 0);
        check("stream_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("stream_v", 32'(v), 32'd1);
            check("stream_dout", 32'(dout), 32'(STREAM_EXP[i]));
            @(negedge clk);
        end
        check("stream_v_end", 32'(v), 32'd0);
        check("stream_dout_hold", 32'(dout), 32'(STREAM_EXP[3]));
        // Pipeline drained: a key load must be accepted again.
        load_key(8'h3C);
        check("ready_after_drain", 32'(cfg_err), 32'd0);

        // Key load while busy is rejected.
        en  = 1'b1;
        din = 8'hFA;
        @(negedge clk);
        en      = 1'b0;
        cfg_en  = 1'b1;
        cfg_key = 8'h11;
        @(negedge clk);
        cfg_en  = 1'b0;
        check("collision_err", 32'(cfg_err), 32'd1);
        @(negedge clk);
        check("collision_err_clear", 32'(cfg_err), 32'd0);
        wait_v(lat, 3);
        check("collision_latency", 32'(lat), 32'(RN + 1));
        check("collision_dout", 32'(dout), 32'h0AF);
        cyc(2);
        send_one("collision_key_kept", 8'h00, enc_m(8'h00, 8'h3C));

        // cfg_en + en together in READY: key taken, word dropped.
        cfg_key = 8'h01;
        cfg_en  = 1'b1;
        en      = 1'b1;
        din     = 8'hFA;
        @(negedge clk);
        cfg_en  = 1'b0;
        en      = 1'b0;
        check("simul_no_err", 32'(cfg_err), 32'd0);
        count_v(8, cnt);
        check("simul_dropped", 32'(cnt), 32'd0);
        send_one("simul_new_key", 8'hFA, enc_m(8'hFA, 8'h01));

        // Reset mid-operation.
        en  = 1'b1;
        din = 8'h33;
        @(negedge clk);
        en  = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_v", 32'(v), 32'd0);
        check("midreset_dout", 32'(dout), 32'd0);
        check("midreset_key_ok", 32'(key_ok), 32'd0);
        cyc(2);
        rst = 1'b1;
        count_v(10, cnt);
        check("midreset_no_v", 32'(cnt), 32'd0);

        // Random traffic against the model.
        load_key(DW'($urandom));
        for (int i = 0; i < 400; i++) begin
            cfg_en  = ($urandom_range(0, 15) == 0);
            cfg_key = DW'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            din     = DW'($urandom);
            @(negedge clk);
        end
        cfg_en = 1'b0;
        en     = 1'b0;
        cyc(RN + 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
